// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory bus between the memory stage and data memory.
//   mem_req    stage -> mem  request, held until mem_ack
//   mem_we     stage -> mem  1 = write, 0 = read
//   mem_addr   stage -> mem  word-aligned byte address
//   mem_wdata  stage -> mem  store data already placed on its byte lane(s)
//   mem_wstrb  stage -> mem  byte-lane write enables
//   mem_rdata  mem -> stage  read word, valid with mem_ack
//   mem_ack    mem -> stage  one-cycle completion pulse
// master = memory stage side, slave = data-memory side.
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory-access stage.
// Accepts one op per cycle while IDLE. Non-memory ops are written back the
// next cycle. Aligned loads/stores issue a held request on the data-memory
// bus and wait for mem_ack; the writeback follows one cycle after the ack.
// Misaligned accesses (and unsupported size codes) skip memory and produce a
// writeback with misalign_err set and the register write suppressed.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready high only in IDLE)
//   instr_type, funct3    op class and access size/sign
//   rd, alu_result        destination register, ALU result / effective address
//   store_data            rs2 value for stores
//   mem                   data-memory bus (mem_stage_if.master)
//   wb_valid, wb_we       writeback pulse and register-file write enable
//   wb_rd, wb_data        writeback register index and value
//   misalign_err          pulse alongside wb_valid on a rejected access
module mem_stage #(
  parameter int WIDTH            = 32,
  parameter int REG_WIDTH        = 5,
  parameter int INSTR_TYPE_WIDTH = 8,
  parameter logic [INSTR_TYPE_WIDTH-1:0] IS_LOAD  = 8'h03,
  parameter logic [INSTR_TYPE_WIDTH-1:0] IS_STORE = 8'h23
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_TYPE_WIDTH-1:0] instr_type,
  input  logic [2:0]                  funct3,
  input  logic [REG_WIDTH-1:0]        rd,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic [WIDTH-1:0]            store_data,
  mem_stage_if.master                 mem,
  output logic                        wb_valid,
  output logic                        wb_we,
  output logic [REG_WIDTH-1:0]        wb_rd,
  output logic [WIDTH-1:0]            wb_data,
  output logic                        misalign_err
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic                   mem_req_reg, mem_req_next;
  logic                   mem_we_reg, mem_we_next;
  logic [WIDTH-1:0]       mem_addr_reg, mem_addr_next;
  logic [WIDTH-1:0]       mem_wdata_reg, mem_wdata_next;
  logic [3:0]             mem_wstrb_reg, mem_wstrb_next;
  logic                   wb_valid_reg, wb_valid_next;
  logic                   wb_we_reg, wb_we_next;
  logic [REG_WIDTH-1:0]   wb_rd_reg, wb_rd_next;
  logic [WIDTH-1:0]       wb_data_reg, wb_data_next;
  logic                   err_reg, err_next;
  // Op details kept for the completion cycle.
  logic [REG_WIDTH-1:0]   rd_reg, rd_next;
  logic [2:0]             funct3_reg, funct3_next;
  logic [1:0]             lane_reg, lane_next;
  logic                   load_reg, load_next;

  logic                   is_load, is_store, access_ok;
  logic [WIDTH-1:0]       shifted, load_data;

  assign is_load  = (instr_type == IS_LOAD);
  assign is_store = (instr_type == IS_STORE);

  // Size/alignment legality. Unsigned sizes exist only for loads, so a
  // store with 100/101 (or any 011/11x code) is rejected like a misalignment.
  always_comb begin
    access_ok = 1'b0;
    case (funct3)
      3'b000:  access_ok = 1'b1;
      3'b001:  access_ok = ~alu_result[0];
      3'b010:  access_ok = (alu_result[1:0] == 2'b00);
      3'b100:  access_ok = is_load;
      3'b101:  access_ok = is_load & ~alu_result[0];
      default: access_ok = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per the size code.
  always_comb begin
    shifted   = mem.mem_rdata >> {lane_reg, 3'b000};
    load_data = shifted;
    case (funct3_reg)
      3'b000:  load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b001:  load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    wb_valid_next  = 1'b0;
    wb_we_next     = 1'b0;
    wb_rd_next     = wb_rd_reg;
    wb_data_next   = wb_data_reg;
    err_next       = 1'b0;
    rd_next        = rd_reg;
    funct3_next    = funct3_reg;
    lane_next      = lane_reg;
    load_next      = load_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          rd_next     = rd;
          funct3_next = funct3;
          lane_next   = alu_result[1:0];
          load_next   = is_load;
          if (!is_load && !is_store) begin
            wb_valid_next = 1'b1;
            wb_we_next    = (rd != '0);
            wb_rd_next    = rd;
            wb_data_next  = alu_result;
          end else if (!access_ok) begin
            wb_valid_next = 1'b1;
            err_next      = 1'b1;
            wb_rd_next    = rd;
            wb_data_next  = alu_result;
          end else begin
            state_next    = MEM_WAIT;
            mem_req_next  = 1'b1;
            mem_we_next   = is_store;
            mem_addr_next = {alu_result[WIDTH-1:2], 2'b00};
            if (is_store) begin
              case (funct3[1:0])
                2'b00: begin
                  mem_wstrb_next = 4'b0001 << alu_result[1:0];
                  mem_wdata_next = {4{store_data[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_next = 4'b0011 << alu_result[1:0];
                  mem_wdata_next = {2{store_data[15:0]}};
                end
                default: begin
                  mem_wstrb_next = 4'b1111;
                  mem_wdata_next = store_data;
                end
              endcase
            end else begin
              mem_wstrb_next = 4'b0000;
            end
          end
        end
      end
      MEM_WAIT: begin
        if (mem.mem_ack) begin
          state_next     = IDLE;
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          mem_wstrb_next = 4'b0000;
          wb_valid_next  = 1'b1;
          wb_rd_next     = rd_reg;
          wb_we_next     = load_reg && (rd_reg != '0);
          wb_data_next   = load_reg ? load_data : '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= 4'b0000;
      wb_valid_reg  <= 1'b0;
      wb_we_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
      err_reg       <= 1'b0;
      rd_reg        <= '0;
      funct3_reg    <= 3'b000;
      lane_reg      <= 2'b00;
      load_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      wb_valid_reg  <= wb_valid_next;
      wb_we_reg     <= wb_we_next;
      wb_rd_reg     <= wb_rd_next;
      wb_data_reg   <= wb_data_next;
      err_reg       <= err_next;
      rd_reg        <= rd_next;
      funct3_reg    <= funct3_next;
      lane_reg      <= lane_next;
      load_reg      <= load_next;
    end
  end

  assign in_ready      = (state_reg == IDLE);
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_we         = wb_we_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign misalign_err  = err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// A transaction-level model predicts every output each cycle; a compare
// process checks the DUT against it on each falling edge. Directed vectors
// add hand-computed literal checks for the key scenarios.
module tb_mem_stage;
  localparam logic [7:0] IS_LOAD  = 8'h03;
  localparam logic [7:0] IS_STORE = 8'h23;
  localparam logic [7:0] OP_ALU   = 8'h33;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  instr_type;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        wb_valid, wb_we, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage_if #(.WIDTH(32)) bus ();

  mem_stage #(
    .WIDTH(32), .REG_WIDTH(5), .INSTR_TYPE_WIDTH(8),
    .IS_LOAD(IS_LOAD), .IS_STORE(IS_STORE)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .funct3(funct3), .rd(rd),
    .alu_result(alu_result), .store_data(store_data), .mem(bus),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic        m_started = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_load, m_signed;
  int          m_size, m_lane;
  logic [4:0]  m_rd;
  logic        e_ready, e_req, e_we, e_wb_valid, e_wb_we, e_err;
  logic [31:0] e_addr, e_wdata, e_wb_data;
  logic [3:0]  e_wstrb;
  logic [4:0]  e_wb_rd;

  task automatic model_step();
    int size;
    logic ok;
    logic [31:0] v, mask;
    e_wb_valid = 1'b0;
    e_err      = 1'b0;
    if (reset) begin
      m_busy = 1'b0; e_req = 1'b0; e_we = 1'b0; e_wstrb = 4'h0;
      e_addr = 32'h0; e_wdata = 32'h0; e_wb_we = 1'b0; e_wb_rd = 5'd0; e_wb_data = 32'h0;
    end else if (!m_busy) begin
      if (in_valid) begin
        size = 1 << funct3[1:0];
        if (instr_type == IS_LOAD) ok = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else                       ok = funct3 inside {3'd0, 3'd1, 3'd2};
        ok = ok && ((int'(alu_result[1:0]) % size) == 0);
        if (instr_type != IS_LOAD && instr_type != IS_STORE) begin
          e_wb_valid = 1'b1; e_wb_we = (rd != 5'd0); e_wb_rd = rd; e_wb_data = alu_result;
        end else if (!ok) begin
          e_wb_valid = 1'b1; e_err = 1'b1; e_wb_we = 1'b0; e_wb_rd = rd; e_wb_data = alu_result;
        end else begin
          m_busy   = 1'b1;
          m_load   = (instr_type == IS_LOAD);
          m_size   = size;
          m_signed = !funct3[2];
          m_rd     = rd;
          m_lane   = int'(alu_result[1:0]);
          e_req    = 1'b1;
          e_we     = !m_load;
          e_addr   = alu_result & 32'hFFFF_FFFC;
          if (m_load) e_wstrb = 4'h0;
          else begin
            e_wstrb = 4'(((1 << size) - 1) << m_lane);
            for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = store_data[8*(i % size) +: 8];
          end
        end
      end
    end else if (bus.mem_ack) begin
      m_busy = 1'b0; e_req = 1'b0; e_wb_valid = 1'b1; e_wb_rd = m_rd;
      if (m_load) begin
        v = bus.mem_rdata >> (8 * m_lane);
        if (m_size < 4) begin
          mask = (32'd1 << (8 * m_size)) - 32'd1;
          v = v & mask;
          if (m_signed && v[8*m_size-1]) v = v | ~mask;
        end
        e_wb_we = (m_rd != 5'd0); e_wb_data = v;
      end else begin
        e_wb_we = 1'b0; e_wb_data = 32'h0;
      end
    end
    e_ready   = !m_busy;
    m_started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
      check("mem_req", {31'b0, bus.mem_req}, {31'b0, e_req});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, e_wb_valid});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, e_err});
      if (e_req) begin
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, e_we});
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, e_wstrb});
        if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
      end
      if (e_wb_valid) begin
        check("wb_we", {31'b0, wb_we}, {31'b0, e_wb_we});
        check("wb_rd", {27'b0, wb_rd}, {27'b0, e_wb_rd});
        check("wb_data", wb_data, e_wb_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [7:0] it, input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] sd);
    in_valid = 1'b1; instr_type = it; funct3 = f3; rd = r; alu_result = a; store_data = sd;
    $display("op type=%02h f3=%0d rd=%0d addr/alu=%08h sd=%08h", it, f3, r, a, sd);
    step();
    in_valid = 1'b0;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rdata);
    repeat (waits) step();
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    step();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr_type = OP_ALU; funct3 = 3'd0; rd = 5'd0;
    alu_result = 32'h0; store_data = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    step();
    reset = 1'b0;

    // Non-memory op.
    issue(OP_ALU, 3'd0, 5'd5, 32'h1234, 32'h0);
    @(negedge clk);
    check("alu wb_valid", {31'b0, wb_valid}, 32'd1);
    check("alu wb_we", {31'b0, wb_we}, 32'd1);
    check("alu wb_rd", {27'b0, wb_rd}, 32'd5);
    check("alu wb_data", wb_data, 32'h1234);
    check("alu mem_req", {31'b0, bus.mem_req}, 32'd0);
    step();

    // LB with three wait cycles, then LBU.
    issue(IS_LOAD, 3'b000, 5'd3, 32'h102, 32'h0);
    @(negedge clk);
    check("lb mem_addr", bus.mem_addr, 32'h100);
    ack_after(3, 32'h0080_0000);
    @(negedge clk);
    check("lb wb_data", wb_data, 32'hFFFF_FF80);
    step();
    issue(IS_LOAD, 3'b100, 5'd3, 32'h102, 32'h0);
    ack_after(3, 32'h0080_0000);
    @(negedge clk);
    check("lbu wb_data", wb_data, 32'h0000_0080);
    step();

    // SH to upper half.
    issue(IS_STORE, 3'b001, 5'd4, 32'h206, 32'h0000_ABCD);
    @(negedge clk);
    check("sh mem_we", {31'b0, bus.mem_we}, 32'd1);
    check("sh mem_addr", bus.mem_addr, 32'h204);
    check("sh mem_wstrb", {28'b0, bus.mem_wstrb}, 32'hC);
    check("sh mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    ack_after(1, 32'h0);
    @(negedge clk);
    check("sh wb_valid", {31'b0, wb_valid}, 32'd1);
    check("sh wb_we", {31'b0, wb_we}, 32'd0);
    step();

    // Misaligned LW.
    issue(IS_LOAD, 3'b010, 5'd6, 32'h101, 32'h0);
    @(negedge clk);
    check("mis mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("mis err", {31'b0, misalign_err}, 32'd1);
    check("mis wb_valid", {31'b0, wb_valid}, 32'd1);
    check("mis wb_we", {31'b0, wb_we}, 32'd0);
    step();

    // Load to x0.
    issue(IS_LOAD, 3'b010, 5'd0, 32'h300, 32'h0);
    ack_after(0, 32'h5555_5555);
    @(negedge clk);
    check("x0 wb_valid", {31'b0, wb_valid}, 32'd1);
    check("x0 wb_we", {31'b0, wb_we}, 32'd0);
    step();

    // Reset in the middle of MEM_WAIT; later ack must not write back.
    issue(IS_LOAD, 3'b010, 5'd7, 32'h400, 32'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("midrst in_ready", {31'b0, in_ready}, 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("midrst no wb", {31'b0, wb_valid}, 32'd0);
    step();

    // Model-checked vectors: lanes, extensions, strobes, odd sizes.
    issue(IS_LOAD, 3'b001, 5'd8, 32'h12, 32'h0);      ack_after(2, 32'h8001_7FFF);
    issue(IS_LOAD, 3'b101, 5'd8, 32'h12, 32'h0);      ack_after(0, 32'h8001_7FFF);
    issue(IS_LOAD, 3'b100, 5'd9, 32'h13, 32'h0);      ack_after(1, 32'hAB00_0000);
    issue(IS_LOAD, 3'b000, 5'd9, 32'h11, 32'h0);      ack_after(1, 32'h0000_7F00);
    issue(IS_STORE, 3'b000, 5'd1, 32'h21, 32'h0000_005A); ack_after(1, 32'h0);
    issue(IS_STORE, 3'b010, 5'd1, 32'h24, 32'hCAFE_F00D); ack_after(4, 32'h0);
    issue(IS_LOAD, 3'b001, 5'd2, 32'h11, 32'h0);      // misaligned half
    issue(IS_LOAD, 3'b011, 5'd2, 32'h40, 32'h0);      // unsupported size
    issue(IS_STORE, 3'b001, 5'd2, 32'h43, 32'h1234);  // misaligned SH

    // Ack while idle is ignored.
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    step();

    // Back-to-back non-memory ops, one per cycle.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; instr_type = OP_ALU; rd = 5'(10 + i); alu_result = 32'h1000 + 32'(i);
      $display("op alu burst rd=%0d alu=%08h", rd, alu_result);
      step();
    end
    in_valid = 1'b0;
    step();

    // Upstream holds an op while a store is in flight.
    issue(IS_STORE, 3'b010, 5'd0, 32'h500, 32'h1122_3344);
    in_valid = 1'b1; instr_type = OP_ALU; rd = 5'd9; alu_result = 32'h99;
    ack_after(2, 32'h0);
    @(negedge clk);
    check("hold store wb_data", wb_data, 32'h0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("hold alu wb_data", wb_data, 32'h99);
    check("hold alu wb_rd", {27'b0, wb_rd}, 32'd9);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
